op_sequencer: RTL and testbench
===============================

# op_sequencer

Host-side initiator for the matrix controller command port. Accepts operation words from a host command stream and drives `operation`, `in_data` and `enable` into the controller. Streams host write data into the controller for serial page writes and collects `out_data` into a host read stream for serial page reads. Enforces the controller's timing rules: opcode hold durations, the idle gap that re-arms the multiply edge detector, and stall-by-enable during writes.

## Interface
Parameters:
- `PAGE_WORDS`, 64: words per serial page write/read (opcode 2/3); range 1..1024.
- `MULT_CYCLES`, 160: cycles opcode 1 is held on `operation`; range 1..1024.
- `RD_LAT`, 1: cycles from opcode-3 issue to matching word on `out_data`; range 0..3.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command word available.
- `cmd_ready` out 1: sequencer accepts command this cycle.
- `cmd_data` in 32: operation word, controller encoding: [3:0] opcode, [7:4] op_a, [11:8] op_b, [15:12] op_c, [19:16] op_d.
- `wr_valid` in 1: host write word available.
- `wr_ready` out 1: write word consumed this cycle.
- `wr_data` in 32: host write word.
- `rd_valid` out 1: `rd_data` holds a read word; no backpressure.
- `rd_data` out 32: read word.
- `ctl_operation` out 32: to controller `operation`.
- `ctl_in_data` out 32: to controller `in_data`.
- `ctl_enable` out 1: to controller `enable`.
- `ctl_out_data` in 32: from controller `out_data`.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse on the cycle a command's phase ends (entry to GAP).

## Operation
- States: IDLE, MULT, WRITE, READ, GAP. 11-bit phase counter `cnt`.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `cmd_data` and branch on its opcode:
  - opcode 1 -> MULT.
  - opcode 2 -> WRITE.
  - opcode 3 -> READ.
  - any other opcode -> GAP, with `done` pulsed and nothing issued.
- `ctl_operation` is registered. It equals the latched word in MULT/WRITE/READ and is 0 in IDLE/GAP.
- MULT: held for exactly MULT_CYCLES cycles, `ctl_enable`=1, then GAP.
- WRITE: `wr_ready`=1. `ctl_in_data`=`wr_data` (combinational). `ctl_enable`=`wr_valid` (combinational), so the controller freezes on bubbles. `cnt` increments per beat (`wr_valid`=1). After the PAGE_WORDS-th beat -> GAP.
- READ: opcode 3 held PAGE_WORDS+RD_LAT cycles, `ctl_enable`=1. Read word k (0-based) is `ctl_out_data` sampled in phase cycle k+RD_LAT, registered onto `rd_data` with `rd_valid`=1 the next cycle. Exactly PAGE_WORDS `rd_valid` pulses per read command.
- GAP: exactly one cycle, `ctl_operation`=0, `ctl_enable`=1, then IDLE. This clears the controller's multiply edge detector before the next command.
- Outside WRITE: `ctl_enable`=1, `ctl_in_data`=0, `wr_ready`=0.

## Timing
- Reset values:
  - `ctl_operation`=0, `ctl_in_data`=0, `ctl_enable`=1.
  - `cmd_ready`=0 during reset, 1 the cycle after.
  - `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0.
- Command accepted in cycle T -> `ctl_operation` shows it from T+1.
- Next command can be accepted earliest at (last phase cycle)+2.
- Minimum command spacing:
  - MULT: MULT_CYCLES+2 cycles.
  - READ: PAGE_WORDS+RD_LAT+2 cycles.
  - WRITE: PAGE_WORDS+2 cycles with no bubbles.
- `cmd_valid` during a non-IDLE state is ignored; `cmd_ready`=0.
- `wr_valid` outside WRITE is not consumed.
- `done` pulses in the same cycle GAP is entered. For an illegal opcode: accepted at T, `done` at T+1, IDLE at T+2.
- Reset mid-phase aborts. The following cycle:
  - state is IDLE, `cnt`=0, `ctl_operation`=0.
  - the read pipeline is flushed, with no further `rd_valid`.
  - the partially written page is abandoned.
- Counter comparisons are against PAGE_WORDS-1 / MULT_CYCLES-1. There is no wrap within a phase.

## Configuration
- `OP_SEQ_STALL_CNT_EN` defined: adds output `stall_cnt` (16 bits, reset 0).
  - Increments on each WRITE cycle with `wr_valid`=0.
  - Saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- Write, PAGE_WORDS=4: cmd 0x0000_0052, then `wr_data` 1,2,3,4 back-to-back.
  - Required: `ctl_operation`=0x52 for 4 cycles with `ctl_enable`=1.
  - `ctl_in_data` sequence 1,2,3,4.
  - `done` on the 5th cycle, then one cycle of `ctl_operation`=0.
- Write with bubbles: `wr_valid` pattern 1,0,0,1,1,0,1.
  - Required: `ctl_enable` follows that pattern, and exactly 4 words are consumed.
  - With the macro, `stall_cnt`=3.
- Read, RD_LAT=1, PAGE_WORDS=4: cmd 0x53, `ctl_out_data` = 0xA0+phase cycle.
  - Required: opcode 3 held 5 cycles.
  - `rd_valid` pulses 4×, with `rd_data` 0xA1,0xA2,0xA3,0xA4.
- Back-to-back mult, MULT_CYCLES=3: two cmds 0x0001_2101 offered continuously.
  - Required: `ctl_operation` pattern 0x12101 ×3, 0, 0x12101 ×3, 0.
  - Second accept occurs 5 cycles after the first.
- Illegal opcode: cmd 0x7.
  - Required: `ctl_operation` stays 0, `done` at T+1, `cmd_ready` back at T+2.
- Reset mid-READ at phase cycle 2.
  - Required: next cycle `ctl_operation`=0, `busy`=0, and no further `rd_valid`.

Source files
------------

// File: rtl/op_sequencer.sv
// op_sequencer: host-side initiator for the matrix controller command port.
// Latency: a command accepted in cycle T drives ctl_operation from T+1; read words
//   appear on rd_data RD_LAT+1 cycles after the matching phase cycle starts.
// Backpressure: cmd_ready only in IDLE; wr_ready only in WRITE (bubbles freeze the
//   controller through ctl_enable); the read stream has no backpressure.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/ready/data  host command stream ([3:0] opcode, [19:4] operands)
//   wr_valid/ready/data   host write-data stream for serial page writes
//   rd_valid/rd_data      host read-data stream for serial page reads
//   ctl_operation/in_data/enable, ctl_out_data   matrix controller command port
//   busy, done            status: not idle, one-cycle pulse on phase end
//   stall_cnt             only when OP_SEQ_STALL_CNT_EN is defined: WRITE bubbles

module op_sequencer #(
  parameter int PAGE_WORDS  = 64,
  parameter int MULT_CYCLES = 160,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] ctl_operation,
  output logic [31:0] ctl_in_data,
  output logic        ctl_enable,
  input  logic [31:0] ctl_out_data,
`ifdef OP_SEQ_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    WRITE,
    READ,
    GAP
  } state_t;

  localparam logic [10:0] MULT_LAST = 11'(MULT_CYCLES - 1);
  localparam logic [10:0] PAGE_LAST = 11'(PAGE_WORDS - 1);
  localparam logic [10:0] READ_LAST = 11'(PAGE_WORDS + RD_LAT - 1);

  state_t      state;
  logic [10:0] cnt;
  logic        in_write;

  // Reset is folded into the combinational outputs so they take their reset
  // values even in the reset cycle itself, regardless of the old state.
  assign in_write    = (state == WRITE) && !reset;
  assign cmd_ready   = (state == IDLE) && !reset;
  assign wr_ready    = in_write;
  assign ctl_in_data = in_write ? wr_data : 32'd0;
  // Dropping enable on a write bubble stalls the controller in place.
  assign ctl_enable  = in_write ? wr_valid : 1'b1;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 11'd0;
      ctl_operation <= 32'd0;
      rd_valid      <= 1'b0;
      rd_data       <= 32'd0;
      done          <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 11'd0;
          if (cmd_valid) begin
            case (cmd_data[3:0])
              4'd1: begin
                state         <= MULT;
                ctl_operation <= cmd_data;
              end
              4'd2: begin
                state         <= WRITE;
                ctl_operation <= cmd_data;
              end
              4'd3: begin
                state         <= READ;
                ctl_operation <= cmd_data;
              end
              default: begin
                // Unknown opcode: nothing is issued, the phase ends at once.
                state <= GAP;
                done  <= 1'b1;
              end
            endcase
          end
        end

        MULT: begin
          if (cnt == MULT_LAST) begin
            state         <= GAP;
            ctl_operation <= 32'd0;
            done          <= 1'b1;
            cnt           <= 11'd0;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end

        WRITE: begin
          // Count only real beats; bubbles leave the page position unchanged.
          if (wr_valid) begin
            if (cnt == PAGE_LAST) begin
              state         <= GAP;
              ctl_operation <= 32'd0;
              done          <= 1'b1;
              cnt           <= 11'd0;
            end else begin
              cnt <= cnt + 11'd1;
            end
          end
        end

        READ: begin
          // The first RD_LAT phase cycles only fill the controller's read path.
          if (int'(cnt) >= RD_LAT) begin
            rd_valid <= 1'b1;
            rd_data  <= ctl_out_data;
          end
          if (cnt == READ_LAST) begin
            state         <= GAP;
            ctl_operation <= 32'd0;
            done          <= 1'b1;
            cnt           <= 11'd0;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end

        GAP: begin
          // One idle-opcode cycle re-arms the controller's multiply edge detector.
          state <= IDLE;
          cnt   <= 11'd0;
        end

        default: begin
          state         <= IDLE;
          cnt           <= 11'd0;
          ctl_operation <= 32'd0;
        end
      endcase
    end
  end

`ifdef OP_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (state == WRITE && !wr_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer with PAGE_WORDS=4, MULT_CYCLES=3, RD_LAT=1.
// Stimulus pushes expected write beats, read words and opcode runs into queues;
// monitors pop and compare whenever the DUT presents them.

module tb_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] ctl_operation;
  logic [31:0] ctl_in_data;
  logic        ctl_enable;
  logic [31:0] ctl_out_data;
  logic        busy;
  logic        done;
`ifdef OP_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_run_op[$];
  int          exp_run_len[$];

  logic [31:0] cur_op  = 32'd0;
  int          run_len = 0;

  op_sequencer #(
    .PAGE_WORDS (4),
    .MULT_CYCLES(3),
    .RD_LAT     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ctl_operation(ctl_operation),
    .ctl_in_data  (ctl_in_data),
    .ctl_enable   (ctl_enable),
    .ctl_out_data (ctl_out_data),
`ifdef OP_SEQ_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: unexpected output 0x%08h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a command until accepted; returns just after the accepting edge.
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = w;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) unexpected("cmd_accept_timeout", w);
    step();
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
  endtask

  // Write-beat monitor: every enabled beat while wr_ready must carry the next word.
  always @(negedge clk) begin
    if (wr_ready && ctl_enable) begin
      if (exp_wr.size() == 0) unexpected("wr_beat", ctl_in_data);
      else chk("wr_beat", ctl_in_data, exp_wr.pop_front());
    end
  end

  // Read monitor.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_rd.size() == 0) unexpected("rd_word", rd_data);
      else chk("rd_word", rd_data, exp_rd.pop_front());
    end
  end

  // Opcode-run monitor: each nonzero run of ctl_operation must match value and length.
  always @(negedge clk) begin
    if (ctl_operation != cur_op) begin
      if (cur_op != 32'd0) begin
        if (exp_run_op.size() == 0) unexpected("op_run", cur_op);
        else begin
          chk("op_run_value", cur_op, exp_run_op.pop_front());
          chk("op_run_len", 32'(run_len), 32'(exp_run_len.pop_front()));
        end
      end
      cur_op  = ctl_operation;
      run_len = 1;
    end else begin
      run_len++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[2];
    int na;
    logic pat[7];
    logic [31:0] wv[7];

    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_data     = 32'd0;
    wr_valid     = 1'b0;
    wr_data      = 32'd0;
    ctl_out_data = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_ctl_enable", 32'(ctl_enable), 32'd1);
    chk("rst_ctl_operation", ctl_operation, 32'd0);
    chk("rst_ctl_in_data", ctl_in_data, 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef OP_SEQ_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    step();

    // Write without bubbles.
    for (int i = 1; i <= 4; i++) exp_wr.push_back(32'(i));
    exp_run_op.push_back(32'h52);
    exp_run_len.push_back(4);
    issue(32'h0000_0052);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'(i + 1);
      @(negedge clk);
      chk("wr1_operation", ctl_operation, 32'h52);
      chk("wr1_enable", 32'(ctl_enable), 32'd1);
      step();
    end
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    @(negedge clk);
    chk("wr1_done", 32'(done), 32'd1);
    chk("wr1_gap_operation", ctl_operation, 32'd0);
    step();
    @(negedge clk);
    chk("wr1_idle_ready", 32'(cmd_ready), 32'd1);
    chk("wr1_idle_busy", 32'(busy), 32'd0);
`ifdef OP_SEQ_STALL_CNT_EN
    chk("wr1_stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // wr_valid outside WRITE is not consumed.
    wr_valid = 1'b1;
    wr_data  = 32'h5555_5555;
    @(negedge clk);
    chk("idle_wr_ready", 32'(wr_ready), 32'd0);
    chk("idle_ctl_in_data", ctl_in_data, 32'd0);
    step();
    wr_valid = 1'b0;
    wr_data  = 32'd0;

    // Write with bubbles: 1,0,0,1,1,0,1.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wv  = '{32'h11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h22, 32'h33, 32'hDEAD_BEEF, 32'h44};
    for (int i = 0; i < 4; i++) exp_wr.push_back(32'h11 * (i + 1));
    exp_run_op.push_back(32'h52);
    exp_run_len.push_back(7);
    issue(32'h0000_0052);
    for (int i = 0; i < 7; i++) begin
      wr_valid = pat[i];
      wr_data  = wv[i];
      @(negedge clk);
      chk("wr2_enable", 32'(ctl_enable), 32'(pat[i]));
      chk("wr2_wr_ready", 32'(wr_ready), 32'd1);
      step();
    end
    wr_valid = 1'b0;
    wr_data  = 32'd0;
    @(negedge clk);
    chk("wr2_done", 32'(done), 32'd1);
    chk("wr2_gap_wr_ready", 32'(wr_ready), 32'd0);
`ifdef OP_SEQ_STALL_CNT_EN
    chk("wr2_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    step();
    step();

    // Read: ctl_out_data = 0xA0 + phase cycle.
    for (int i = 1; i <= 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    exp_run_op.push_back(32'h53);
    exp_run_len.push_back(5);
    issue(32'h0000_0053);
    for (int c = 0; c < 5; c++) begin
      ctl_out_data = 32'hA0 + 32'(c);
      @(negedge clk);
      chk("rd_operation", ctl_operation, 32'h53);
      step();
    end
    ctl_out_data = 32'd0;
    @(negedge clk);
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_gap_operation", ctl_operation, 32'd0);
    step();
    step();

    // Back-to-back multiply commands offered continuously.
    exp_run_op.push_back(32'h0001_2101);
    exp_run_len.push_back(3);
    exp_run_op.push_back(32'h0001_2101);
    exp_run_len.push_back(3);
    na        = 0;
    acc       = '{0, 0};
    cmd_valid = 1'b1;
    cmd_data  = 32'h0001_2101;
    for (int n = 0; n < 30 && na < 2; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc[na] = cyc;
        na++;
      end
      step();
    end
    cmd_valid = 1'b0;
    cmd_data  = 32'd0;
    chk("mult_accepts", 32'(na), 32'd2);
    chk("mult_spacing", 32'(acc[1] - acc[0]), 32'd5);
    repeat (6) step();

    // Illegal opcode.
    issue(32'h0000_0007);
    @(negedge clk);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_operation", ctl_operation, 32'd0);
    chk("ill_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    @(negedge clk);
    chk("ill_ready_back", 32'(cmd_ready), 32'd1);
    chk("ill_done_clear", 32'(done), 32'd0);
    step();

    // Reset mid-READ at phase cycle 2: only word 0 escapes before the flush.
    exp_rd.push_back(32'hA1);
    exp_run_op.push_back(32'h53);
    exp_run_len.push_back(3);
    issue(32'h0000_0053);
    for (int c = 0; c < 2; c++) begin
      ctl_out_data = 32'hA0 + 32'(c);
      step();
    end
    ctl_out_data = 32'hA2;
    reset        = 1'b1;
    step();
    reset        = 1'b0;
    ctl_out_data = 32'hA3;
    @(negedge clk);
    chk("abort_operation", ctl_operation, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) step();
    ctl_out_data = 32'd0;

    chk("left_wr", 32'(exp_wr.size()), 32'd0);
    chk("left_rd", 32'(exp_rd.size()), 32'd0);
    chk("left_runs", 32'(exp_run_op.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
